sram_port_arbiter: RTL and testbench

// - Shares the single data-side SRAM interface port of sram_top between two requesters:
//   req 0 is the host AXI4-to-RAM bridge and req 1 is the tile DMA/prefetch engine.
// - Round-robin arbitration with bounded burst locking.
// - Tracks in-flight reads through the fixed SRAM read latency and routes each read data beat back to its issuer.

---
 rtl/sram_port_arbiter_pkg.sv | 12 +
 rtl/sram_port_arbiter_if.sv | 34 +++
 rtl/sram_port_arbiter_rd_tag_pipe.sv | 30 +++
 rtl/sram_port_arbiter.sv | 116 +++++++++++
 tb/tb_sram_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;
  typedef enum logic {ARB_ST, LOCKED_ST} arb_state_t;

  localparam int REQ_HOST = 0;
  localparam int REQ_DMA  = 1;

  typedef struct packed {
    logic v;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester- and SRAM-side bundle of the port arbiter; master = requesters/SRAM, slave = arbiter.
interface sram_port_arbiter_if #(
  parameter int IF_W     = 128,
  parameter int IF_ADR_W = 32
);
  logic [1:0]                i_req_valid;
  logic [1:0]                o_req_ready;
  logic [1:0]                i_req_we;
  logic [1:0]                i_req_lock;
  logic [1:0][IF_ADR_W-1:0]  i_req_addr;
  logic [1:0][IF_W-1:0]      i_req_wdata;
  logic [1:0][IF_W-1:0]      i_req_wmask;
  logic [1:0]                o_rsp_valid;
  logic [IF_W-1:0]           o_rsp_data;
  logic [IF_ADR_W-1:0]       o_ram_addr;
  logic [IF_W-1:0]           o_ram_din;
  logic [IF_W-1:0]           o_ram_wmask;
  logic                      o_ram_wren;
  logic                      o_ram_rden;
  logic [IF_W-1:0]           i_ram_dout;
  logic                      o_busy;

  modport master (
    output i_req_valid, i_req_we, i_req_lock, i_req_addr, i_req_wdata, i_req_wmask, i_ram_dout,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_ram_addr, o_ram_din, o_ram_wmask,
           o_ram_wren, o_ram_rden, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_lock, i_req_addr, i_req_wdata, i_req_wmask, i_ram_dout,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_ram_addr, o_ram_din, o_ram_wmask,
           o_ram_wren, o_ram_rden, o_busy
  );
endinterface

// File: rtl/sram_port_arbiter_rd_tag_pipe.sv
// Fixed-latency read tag delay line: tag loaded at acceptance pops out RD_LAT cycles later.
module rd_tag_pipe
  import sram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    i_clk,
  input  logic    i_clr,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag,
  output logic    o_any
);
  rd_tag_t [RD_LAT-1:0] tag_pipe;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign o_tag = tag_pipe[RD_LAT-1];

  always_comb begin
    o_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) o_any = o_any | tag_pipe[i].v;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with bounded burst locking sharing one SRAM port between host and DMA,
// routing fixed-latency read data back to the issuing requester.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int IF_W     = 128,
  parameter int IF_ADR_W = 32,
  parameter int RD_LAT   = 2,
  parameter int MAX_LOCK = 16
) (
  input logic                i_clk,
  input logic                i_rst,
  sram_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t        state_q, state_n;
  logic              rr_last_q, rr_last_n;
  logic              owner_q, owner_n;
  logic              sel_q, sel_n;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_n;

  logic [1:0]        gnt;
  logic              lock_act, xfer, gid, sel;
  logic [IF_ADR_W-1:0] addr_mux;
  logic [IF_W-1:0]     din_mux, wmask_mux;
  rd_tag_t           tag_in, tag_out;
  logic              tag_any;

  // A locked owner that drops valid releases the port in the same cycle.
  always_comb begin
    gnt      = '0;
    lock_act = (state_q == LOCKED_ST) && bus.i_req_valid[owner_q];
    if (i_rst)                   gnt = '0;
    else if (lock_act)           gnt[owner_q] = 1'b1;
    else if (&bus.i_req_valid)   gnt[~rr_last_q] = 1'b1;
    else                         gnt = bus.i_req_valid;
  end

  assign xfer = |gnt;
  assign gid  = gnt[1];

  always_comb begin
    state_n    = state_q;
    rr_last_n  = rr_last_q;
    owner_n    = owner_q;
    sel_n      = sel_q;
    lock_cnt_n = lock_cnt_q;
    if (lock_act) begin
      rr_last_n  = owner_q;
      sel_n      = owner_q;
      // lock_cnt_n counts this beat; the MAX_LOCK-th beat closes the burst.
      lock_cnt_n = lock_cnt_q + 1'b1;
      if (!bus.i_req_lock[owner_q] || lock_cnt_n == CNT_W'(MAX_LOCK)) begin
        state_n    = ARB_ST;
        lock_cnt_n = '0;
      end
    end else begin
      state_n    = ARB_ST;
      lock_cnt_n = '0;
      if (xfer) begin
        rr_last_n = gid;
        sel_n     = gid;
        if (bus.i_req_lock[gid] && MAX_LOCK > 1) begin
          state_n    = LOCKED_ST;
          owner_n    = gid;
          lock_cnt_n = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ARB_ST;
      rr_last_q  <= 1'(REQ_DMA);
      owner_q    <= 1'(REQ_HOST);
      sel_q      <= 1'(REQ_HOST);
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      rr_last_q  <= rr_last_n;
      owner_q    <= owner_n;
      sel_q      <= sel_n;
      lock_cnt_q <= lock_cnt_n;
    end
  end

  // Memory side: idle cycles keep presenting the last granted requester's fields.
  assign sel       = xfer ? gid : sel_q;
  assign addr_mux  = bus.i_req_addr[sel];
  assign din_mux   = bus.i_req_wdata[sel];
  assign wmask_mux = bus.i_req_wmask[sel];

  assign bus.o_ram_addr  = addr_mux;
  assign bus.o_ram_din   = din_mux;
  assign bus.o_ram_wmask = wmask_mux;
  assign bus.o_ram_wren  = xfer &  bus.i_req_we[gid];
  assign bus.o_ram_rden  = xfer & ~bus.i_req_we[gid];
  assign bus.o_req_ready = gnt;

  assign tag_in.v  = bus.o_ram_rden;
  assign tag_in.id = gid;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_tag (tag_in),
    .o_tag (tag_out),
    .o_any (tag_any)
  );

  assign bus.o_rsp_valid = tag_out.v ? (tag_out.id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_rsp_data  = bus.i_ram_dout;
  assign bus.o_busy      = (state_q == LOCKED_ST) | tag_any;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-cycle grant table plus read-latency/reset sequences.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int IF_W     = 128;
  localparam int IF_ADR_W = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.IF_W(IF_W), .IF_ADR_W(IF_ADR_W)) bus ();

  sram_port_arbiter #(
    .IF_W(IF_W), .IF_ADR_W(IF_ADR_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Unwritten SRAM words read back as a fixed address-derived pattern.
  function automatic logic [IF_W-1:0] pat(input logic [7:0] a);
    return {16{a}} ^ {4{32'hC0DE_F00D}};
  endfunction

  logic [IF_W-1:0] mem [256];
  logic [255:0]    written = '0;
  logic [IF_W-1:0] rd_q [RD_LAT];
  logic [7:0]      ma;
  assign ma = bus.o_ram_addr[7:0];

  always @(posedge clk) begin
    if (bus.o_ram_wren) begin
      mem[ma]     <= ((written[ma] ? mem[ma] : pat(ma)) & ~bus.o_ram_wmask) |
                     (bus.o_ram_din & bus.o_ram_wmask);
      written[ma] <= 1'b1;
    end
    rd_q[0] <= bus.o_ram_rden ? (written[ma] ? mem[ma] : pat(ma)) : '0;
    for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign bus.i_ram_dout = rd_q[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [IF_W-1:0] got, input logic [IF_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [IF_W-1:0] wd, input logic [IF_W-1:0] wm);
    @(posedge clk); #1;
    bus.i_req_valid = v;
    bus.i_req_we    = we;
    bus.i_req_lock  = lk;
    bus.i_req_addr  = {IF_ADR_W'(a1), IF_ADR_W'(a0)};
    bus.i_req_wdata = {wd, wd};
    bus.i_req_wmask = {wm, wm};
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_we    = '0;
    bus.i_req_lock  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] v, we, lk;
    logic [1:0] rdy;
    logic       rden, wren;
    logic [7:0] addr;
  } vec_t;

  vec_t vecs [25];

  localparam logic [IF_W-1:0] A5   = {16{8'hA5}};
  localparam logic [IF_W-1:0] H5A  = {16{8'h5A}};
  localparam logic [IF_W-1:0] ONES = '1;
  localparam logic [IF_W-1:0] LOW  = {{(IF_W/2){1'b0}}, {(IF_W/2){1'b1}}};

  logic [IF_W-1:0] p44;

  initial begin
    // v, we, lock, ready, rden, wren, addr  (MAX_LOCK=4, starting from reset)
    vecs[0]  = '{2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[1]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[2]  = '{2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[3]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[4]  = '{2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[5]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[6]  = '{2'b11, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 8'h10};
    vecs[7]  = '{2'b11, 2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 8'h20};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h20};
    vecs[9]  = '{2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[10] = '{2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[11] = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[12] = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[13] = '{2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[14] = '{2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[15] = '{2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[16] = '{2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[17] = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[18] = '{2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[19] = '{2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[20] = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[21] = '{2'b11, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[22] = '{2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10};
    vecs[23] = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20};
    vecs[24] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h20};

    bus.i_req_valid = '0;
    bus.i_req_we    = '0;
    bus.i_req_lock  = '0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_req_wmask = '0;

    do_reset();
    chk("reset_ready", bus.o_req_ready, 2'b00);
    chk("reset_rsp",   bus.o_rsp_valid, 2'b00);
    chk("reset_wren",  bus.o_ram_wren, 1'b0);
    chk("reset_rden",  bus.o_ram_rden, 1'b0);
    chk("reset_busy",  bus.o_busy, 1'b0);

    // single reads: req0 @0x10 then req1 @0x20
    cyc(2'b01, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("sr_ready0", bus.o_req_ready, 2'b01);
    chk("sr_rden0",  bus.o_ram_rden, 1'b1);
    chk("sr_addr0",  bus.o_ram_addr, 32'h10);
    cyc(2'b10, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("sr_ready1", bus.o_req_ready, 2'b10);
    chk("sr_rden1",  bus.o_ram_rden, 1'b1);
    chk("sr_addr1",  bus.o_ram_addr, 32'h20);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("sr_rden_off", bus.o_ram_rden, 1'b0);
    chk("sr_rsp0",     bus.o_rsp_valid, 2'b01);
    chk("sr_data0",    bus.o_rsp_data, pat(8'h10));
    chk("sr_busy",     bus.o_busy, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("sr_rsp1",  bus.o_rsp_valid, 2'b10);
    chk("sr_data1", bus.o_rsp_data, pat(8'h20));
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("sr_rsp_idle", bus.o_rsp_valid, 2'b00);
    chk("sr_busy_idle", bus.o_busy, 1'b0);

    // grant/lock table from a fresh reset
    do_reset();
    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].v, vecs[i].we, vecs[i].lk, 8'h10, 8'h20, '0, '0);
      chk($sformatf("vec%0d_ready", i), bus.o_req_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_rden", i),  bus.o_ram_rden, vecs[i].rden);
      chk($sformatf("vec%0d_wren", i),  bus.o_ram_wren, vecs[i].wren);
      chk($sformatf("vec%0d_addr", i),  bus.o_ram_addr, IF_ADR_W'(vecs[i].addr));
    end
    repeat (3) cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("drain_busy", bus.o_busy, 1'b0);

    // write then read-back by req1, full mask
    cyc(2'b10, 2'b10, 2'b00, 8'h10, 8'h40, A5, ONES);
    chk("wb_ready", bus.o_req_ready, 2'b10);
    chk("wb_wren",  bus.o_ram_wren, 1'b1);
    chk("wb_rden",  bus.o_ram_rden, 1'b0);
    chk("wb_din",   bus.o_ram_din, A5);
    cyc(2'b10, 2'b00, 2'b00, 8'h10, 8'h40, '0, '0);
    chk("wb_rd_rden", bus.o_ram_rden, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h40, '0, '0);
    chk("wb_rsp_early", bus.o_rsp_valid, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h40, '0, '0);
    chk("wb_rsp",  bus.o_rsp_valid, 2'b10);
    chk("wb_data", bus.o_rsp_data, A5);

    // half-mask write keeps the upper half
    p44 = pat(8'h44);
    cyc(2'b10, 2'b10, 2'b00, 8'h10, 8'h44, H5A, LOW);
    chk("hm_wmask", bus.o_ram_wmask, LOW);
    cyc(2'b10, 2'b00, 2'b00, 8'h10, 8'h44, '0, '0);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h44, '0, '0);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h44, '0, '0);
    chk("hm_rsp",  bus.o_rsp_valid, 2'b10);
    chk("hm_data", bus.o_rsp_data, {p44[IF_W-1:IF_W/2], H5A[IF_W/2-1:0]});

    // reset the cycle after an accepted read
    do_reset();
    cyc(2'b01, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("rm_ready", bus.o_req_ready, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_req_valid = 2'b00;
    @(negedge clk);
    chk("rm_busy_inflight", bus.o_busy, 1'b1);
    chk("rm_rsp_inrst", bus.o_rsp_valid, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_req_valid = 2'b11;
    @(negedge clk);
    chk("rm_rsp_dropped", bus.o_rsp_valid, 2'b00);
    chk("rm_busy", bus.o_busy, 1'b0);
    chk("rm_first_grant", bus.o_req_ready, 2'b01);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("rm_rsp_none", bus.o_rsp_valid, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, '0, '0);
    chk("rm_rsp_post", bus.o_rsp_valid, 2'b01);
    chk("rm_data_post", bus.o_rsp_data, pat(8'h10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
